axis_frame_gen: RTL
===================

Name: axis_frame_gen

Overview:
- AXI4-Stream master (transmitter) that emits test frames into downstream stream slices and sinks.
- On a start pulse it sends frame_len beats of incrementing data from a seed value, with tlast on the final beat.
- It honours backpressure from m_axis_tready, inserts a fixed idle gap between frames, and reports busy, done and a running frame count.

Parameters:
- DATA_WIDTH, 32, width of m_axis_tdata and seed
- LEN_WIDTH, 16, width of frame_len and the internal beat counter
- GAP_CYCLES, 2, idle cycles after a frame before a new start is accepted (0 allowed)
- CNT_WIDTH, 16, width of frame_count

Ports:
- axi_clk  in  1  clock; all logic is rising-edge
- axi_resetn  in  1  reset; asynchronous, active-low
- start  in  1  request a frame; sampled only in IDLE
- frame_len  in  LEN_WIDTH  beats per frame; latched at accepted start
- seed  in  DATA_WIDTH  first beat's data; latched at accepted start
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse after the last beat's handshake
- frame_count  out  CNT_WIDTH  completed frames; wraps at 2^CNT_WIDTH
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready from the sink
- m_axis_tlast  out  1  marks the final beat of a frame
- m_axis_tdata  out  DATA_WIDTH  stream data

Behaviour:
- Reset (axi_resetn=0, takes effect immediately regardless of clock):
  - state=IDLE
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0
  - busy=0, done=0, frame_count=0
  - internal length, seed and beat counters cleared.
- Reset mid-frame aborts the frame: no tlast is emitted, frame_count is not incremented, done does not pulse. After release the block is in IDLE.
- All outputs are registered. m_axis_tvalid never depends combinationally on m_axis_tready.
- A handshake is m_axis_tvalid & m_axis_tready at a rising edge.
- States: IDLE, SEND, GAP.
- IDLE:
  - start=1 and frame_len!=0 at an edge: latch frame_len and seed, go to SEND.
  - On that same edge: m_axis_tvalid<=1, m_axis_tdata<=seed, m_axis_tlast<=(frame_len==1), beat counter<=0.
  - Latency from the start edge to tvalid visible is 1 cycle.
  - start=1 with frame_len==0 is ignored: stay in IDLE, no done.
- SEND:
  - Without a handshake, tvalid, tdata and tlast are held stable; the AXI rule of never retracting or altering a pending beat applies.
  - On a handshake of a non-last beat: tdata<=tdata+1 (mod 2^DATA_WIDTH, so all-ones wraps to 0), beat counter+1. tlast<=1 when the new beat index equals len-1, otherwise 0.
  - On a handshake of the last beat (tlast=1): tvalid<=0, tlast<=0, tdata<=0, done<=1 for exactly one cycle, frame_count<=frame_count+1 (wraps).
  - Next state after the last beat is GAP if GAP_CYCLES>0, else IDLE.
- GAP: a counter runs GAP_CYCLES cycles, then the block returns to IDLE. Outputs are idle (tvalid=0, tdata=0, tlast=0).
- start is ignored in SEND and GAP; it is not queued.
- frame_len or seed changing during SEND has no effect on the frame in flight.
- With tready tied to 1, a frame of L beats has tvalid high for exactly L consecutive cycles. The minimum start-to-start period is L+GAP_CYCLES+1 cycles.
- busy is 1 from the cycle after the accepted start until the return to IDLE.
- done is asserted in the cycle where busy is still high (GAP), or where busy falls if GAP_CYCLES=0.

Test Plan:
- Reset values: hold axi_resetn=0, then release -> all outputs 0, busy=0. Pulse start with frame_len=4, seed=0x10, tready=1 -> beats 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles; tlast only on 0x13; done pulses once; frame_count=1.
- Backpressure: frame_len=3, seed=0xA0, tready low for 3 cycles on each beat -> tdata and tlast stable while stalled; exactly 3 handshakes 0xA0..0xA2; tlast only on 0xA2.
- Edge lengths and wrap: frame_len=1, seed=0x5 -> a single beat with tlast=1 and tvalid for 1 cycle. frame_len=0 -> no tvalid, no done, frame_count unchanged. seed=0xFFFFFFFE, frame_len=3 -> data 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Gap and ignored start: hold start=1 continuously with frame_len=2 and GAP_CYCLES=2 -> frames begin every 5 cycles; no start is accepted during SEND or GAP; frame_count increments each frame.
- Reset mid-frame: assert axi_resetn=0 asynchronously (between edges) during beat 2 of 5 -> tvalid drops immediately; no tlast, no done; frame_count stays at its prior value. A subsequent start runs a full frame from the new seed.
- Counter wrap: CNT_WIDTH=2, run 5 frames of length 1 -> frame_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/axis_frame_gen.sv
// ---------------------------------------------------------------------------
// axis_frame_gen
//
// AXI4-Stream master that emits test frames. A start request in IDLE launches
// a frame of frame_len beats carrying incrementing data from seed, with tlast
// on the final beat. Backpressure from m_axis_tready is honoured. A fixed idle
// gap follows every frame before another start is accepted.
//
// Ports:
//   axi_clk        rising-edge clock
//   axi_resetn     asynchronous active-low reset
//   start          frame request, sampled only in IDLE
//   frame_len      beats per frame, latched at an accepted start (0 = ignored)
//   seed           data of the first beat, latched at an accepted start
//   busy           high whenever the block is not IDLE
//   done           one-cycle pulse after the last beat's handshake
//   frame_count    completed frames, wrapping
//   m_axis_tvalid  stream valid (registered, independent of tready)
//   m_axis_tready  stream ready from the sink
//   m_axis_tlast   final beat of a frame
//   m_axis_tdata   stream data
// ---------------------------------------------------------------------------
module axis_frame_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  axi_clk,
    input  logic                  axi_resetn,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata
);

    // Gap counter sized for at least one bit so GAP_CYCLES of 0 or 1 still
    // elaborates; the GAP state is simply never entered when GAP_CYCLES is 0.
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                state_q,  state_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q,  tlast_d;
    logic [DATA_WIDTH-1:0] tdata_q,  tdata_d;
    logic [LEN_WIDTH-1:0]  len_q,    len_d;
    logic [LEN_WIDTH-1:0]  beat_q,   beat_d;
    logic [GW-1:0]         gap_q,    gap_d;
    logic                  done_q,   done_d;
    logic                  busy_q,   busy_d;
    logic [CNT_WIDTH-1:0]  count_q,  count_d;

    logic                  handshake;
    logic [LEN_WIDTH-1:0]  beat_inc;
    logic [LEN_WIDTH-1:0]  len_last;

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q  <= ST_IDLE;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            gap_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tdata_d   = tdata_q;
        len_d     = len_q;
        beat_d    = beat_q;
        gap_d     = gap_q;
        count_d   = count_q;
        done_d    = 1'b0;
        handshake = tvalid_q & m_axis_tready;
        beat_inc  = beat_q + LEN_WIDTH'(1);
        len_last  = len_q - LEN_WIDTH'(1);

        case (state_q)
            ST_IDLE: begin
                // A zero-length request is dropped without side effects.
                if (start && (frame_len != '0)) begin
                    state_d  = ST_SEND;
                    len_d    = frame_len;
                    tvalid_d = 1'b1;
                    tdata_d  = seed;
                    tlast_d  = (frame_len == LEN_WIDTH'(1));
                    beat_d   = '0;
                end
            end
            ST_SEND: begin
                // Without a handshake everything holds: a pending beat is
                // never altered or withdrawn.
                if (handshake) begin
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = '0;
                        done_d   = 1'b1;
                        count_d  = count_q + CNT_WIDTH'(1);
                        gap_d    = '0;
                        if (GAP_CYCLES > 0) begin
                            state_d = ST_GAP;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tdata_d = tdata_q + DATA_WIDTH'(1);
                        beat_d  = beat_inc;
                        tlast_d = (beat_inc == len_last);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                tdata_d  = '0;
            end
        endcase

        // busy is registered from the next state so it tracks state_q exactly.
        busy_d = (state_d != ST_IDLE);
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign frame_count   = count_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdata  = tdata_q;

endmodule
